// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer with a programmable divider.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DIV_RESET  = 106,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          div_we,
    input  logic [31:0]                   div_di,
    output logic [31:0]                   div_do,
    input  logic                          dat_we,
    input  logic [7:0]                    dat_di,
    output logic                          dat_wait,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          ser_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [31:0] div_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, per_q, per_d, per_new;
    logic [7:0]  shreg_q, shreg_d, rd_data;
    logic [2:0]  bit_q, bit_d;
    logic        ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`endif

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push    = dat_we && !full;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign per_new = (div_q < 32'd2) ? 32'd2 : div_q;

    assign div_do     = div_q;
    assign dat_wait   = full;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign ser_tx     = ser_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= 32'(DIV_RESET);
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (div_we) div_q    <= div_di;
            if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= dat_di;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            per_q   <= 32'd2;
            shreg_q <= '0;
            bit_q   <= '0;
            ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // ser_d is the line level of the next state, so ser_tx changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        ser_d   = ser_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                ser_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    per_d   = per_new;
                    cnt_d   = per_new - 32'd1;
                    shreg_d = rd_data;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^rd_data;
`endif
                    state_d = S_START;
                    ser_d   = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = per_q - 32'd1;
                    bit_d   = '0;
                    state_d = S_DATA;
                    ser_d   = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d   = per_q - 32'd1;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        ser_d   = par_q;
`else
                        state_d = S_STOP;
                        ser_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        ser_d = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    cnt_d   = per_q - 32'd1;
                    state_d = S_STOP;
                    ser_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        per_d   = per_new;
                        cnt_d   = per_new - 32'd1;
                        shreg_d = rd_data;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^rd_data;
`endif
                        state_d = S_START;
                        ser_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        ser_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ser_d   = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a line monitor decodes
// every frame at clock resolution and checks bit timing and content.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        div_we = 1'b0;
    logic [31:0] div_di = '0;
    logic [31:0] div_do;
    logic        dat_we = 1'b0;
    logic [7:0]  dat_di = '0;
    logic        dat_wait;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        ser_tx;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  sb[$];
    int          starts[$];
    logic [31:0] mdiv;
    int          cyc = 0;

    uart_tx_fifo #(.DIV_RESET(106), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .div_we(div_we), .div_di(div_di), .div_do(div_do),
        .dat_we(dat_we), .dat_di(dat_di), .dat_wait(dat_wait), .fifo_level(fifo_level),
        .busy(busy), .ser_tx(ser_tx)
    );

    always #5 clk = ~clk;

    // Architectural divider register as the bus sees it.
    always @(posedge clk or negedge reset_n)
        if (!reset_n) mdiv <= 32'd106;
        else if (div_we) mdiv <= div_di;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Line monitor: every negedge inside a frame must show the bit owning that slot.
    initial begin : monitor
        logic        active = 1'b0, have_exp = 1'b0, ok = 1'b1;
        logic [10:0] bits = '0;
        logic [7:0]  got = '0, exp_b = '0;
        logic [31:0] div_prev = 32'd106;
        int n = 0, p = 2, k = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                active = 1'b0;
            end else begin
                if (!active && ser_tx === 1'b0) begin
                    active = 1'b1;
                    n = 0;
                    ok = 1'b1;
                    got = '0;
                    p = (div_prev < 2) ? 2 : int'(div_prev);
                    starts.push_back(cyc);
                    if (sb.size() == 0) begin
                        have_exp = 1'b0;
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        have_exp = 1'b1;
                        exp_b = sb.pop_front();
                    end
                    bits = '1;
                    bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) bits[i+1] = exp_b[i];
                    if (NB == 11) bits[9] = ^exp_b;
                end
                if (active) begin
                    k = n / p;
                    if (ser_tx !== bits[k]) ok = 1'b0;
                    if ((n % p) == (p / 2) && k >= 1 && k <= 8) got[k-1] = ser_tx;
                    n++;
                    if (n == NB * p) begin
                        active = 1'b0;
                        if (have_exp) begin
                            check("frame_data", {24'd0, got}, {24'd0, exp_b});
                            check("frame_timing", {31'd0, ok}, 32'd1);
                        end
                    end
                end
            end
            div_prev = mdiv;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        while (dat_wait && t < 5000) begin step(); t++; end
        check("push_wait_timeout", {31'd0, dat_wait}, 32'd0);
        dat_we = 1'b1;
        dat_di = b;
        sb.push_back(b);
        step();
        dat_we = 1'b0;
    endtask

    task automatic set_div(input logic [31:0] v);
        div_we = 1'b1;
        div_di = v;
        step();
        div_we = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((busy || sb.size() != 0) && t < budget) begin step(); t++; end
        check("drain_timeout", {31'd0, busy}, 32'd0);
        repeat (2) step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int cnt, s0, p;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        check("rst_ser_tx", {31'd0, ser_tx}, 32'd1);
        check("rst_div_do", div_do, 32'd106);
        check("rst_fifo_level", {28'd0, fifo_level}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dat_wait", {31'd0, dat_wait}, 32'd0);

        // Single 'A' frame at default divider; latency and busy duration.
        push(8'h41);
        check("lat_level_e0", {28'd0, fifo_level}, 32'd1);
        check("lat_busy_e0", {31'd0, busy}, 32'd1);
        step();
        check("lat_level_e1", {28'd0, fifo_level}, 32'd0);
        check("lat_ser_e1", {31'd0, ser_tx}, 32'd0);
        cnt = 2;
        while (busy && cnt < 5000) begin step(); if (busy) cnt++; end
        check("busy_clocks", cnt, NB * 106 + 1);
        drain(100);

        // Fill the FIFO back-to-back; one write while full must be dropped.
        set_div(32'd4);
        s0 = starts.size();
        dat_we = 1'b1;
        for (int k = 0; k < 9; k++) begin
            dat_di = 8'h30 + 8'(k);
            sb.push_back(dat_di);
            step();
            check("fill_level", {28'd0, fifo_level}, (k == 0) ? 32'd1 : 32'(k));
            check("fill_wait", {31'd0, dat_wait}, (k == 8) ? 32'd1 : 32'd0);
        end
        dat_di = 8'h99;
        step();
        check("full_drop_level", {28'd0, fifo_level}, 32'd8);
        dat_we = 1'b0;
        drain(2000);
        check("fill_frames", starts.size() - s0, 9);
        for (int i = 1; i < 9 && s0 + i < starts.size(); i++)
            check("b2b_gap", starts[s0+i] - starts[s0+i-1], NB * 4);

        // div=0 clamps to a 2-clock bit; parity-sensitive bytes.
        set_div(32'd0);
        check("div_do_zero", div_do, 32'd0);
        push(8'h5A);
        push(8'h07);
        push(8'h03);
        drain(500);

        // Divider rewrite mid-frame affects only the next frame.
        set_div(32'd8);
        s0 = starts.size();
        push(8'hC3);
        push(8'h3C);
        repeat (30) step();
        set_div(32'd20);
        check("div_do_mid", div_do, 32'd20);
        drain(1000);
        if (starts.size() >= s0 + 2)
            check("div_mid_frame1_len", starts[s0+1] - starts[s0], NB * 8);
        else
            check("div_mid_frames", starts.size() - s0, 2);

        // Reset during DATA of the second of three frames.
        set_div(32'd10);
        s0 = starts.size();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        cnt = 0;
        while (starts.size() < s0 + 2 && cnt < 1000) begin step(); cnt++; end
        check("rst_mid_reach_frame2", starts.size() - s0, 2);
        repeat (30) step();
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("rstmid_ser_tx", {31'd0, ser_tx}, 32'd1);
        check("rstmid_level", {28'd0, fifo_level}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_div", div_do, 32'd106);
        repeat (3) step();
        reset_n = 1'b1;
        s0 = starts.size();
        repeat (300) step();
        check("rstmid_no_frames", starts.size() - s0, 0);
        check("rstmid_idle_ser", {31'd0, ser_tx}, 32'd1);

        // Randomized rounds: random divider, bytes, and gaps.
        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(0, 6));
            set_div(32'(p));
            check("rand_div_do", div_do, 32'(p));
            cnt = int'($urandom_range(3, 10));
            for (int j = 0; j < cnt; j++) begin
                push(8'($urandom));
                repeat ($urandom_range(0, 12)) step();
            end
            drain(5000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
